apb_master: RTL and testbench

- Upstream bridge that converts a simple valid/ready command stream into APB transfers, driving the shared APB slave port (P_addr, P_selx, P_enable, P_write, P_wdata).
- Collects P_ready, P_rdata and P_slverr, and returns one response per command.
- Sits between the team's internal request logic and the APB memory slave.
- Adds a wait-state timeout so a hung slave cannot stall the requester.

---
 rtl/apb_master.sv | 145 ++++++++++++++
 tb/tb_apb_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: converts a valid/ready command stream into APB transfers.
// Single outstanding transfer; one response per command. A wait-state
// timeout keeps a hung slave from stalling the requester.
module apb_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              P_clk,
  input  logic              P_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Last wait-counter value allowed before the transfer is aborted.
  localparam int unsigned TO_M1   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [7:0]  TO_LAST = TO_M1[7:0];

  state_t            state, state_next;
  logic [7:0]        wait_cnt, wait_cnt_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next;
  logic              write_next;
  logic              selx_next, enable_next;
  logic              rsp_valid_next, rsp_err_next, rsp_timeout_next;
  logic [DATA_W-1:0] rsp_rdata_next;

  assign cmd_ready = (state == IDLE);

  // State register and registered outputs; reset drops the bus at once.
  always_ff @(posedge P_clk or posedge P_rst) begin
    if (P_rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      P_addr      <= '0;
      P_wdata     <= '0;
      P_write     <= 1'b0;
      P_selx      <= 1'b0;
      P_enable    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      P_addr      <= addr_next;
      P_wdata     <= wdata_next;
      P_write     <= write_next;
      P_selx      <= selx_next;
      P_enable    <= enable_next;
      rsp_valid   <= rsp_valid_next;
      rsp_rdata   <= rsp_rdata_next;
      rsp_err     <= rsp_err_next;
      rsp_timeout <= rsp_timeout_next;
    end
  end

  // Next-state and next-output decode; outputs are computed one cycle
  // ahead so every bus and response signal leaves a flop.
  always_comb begin
    state_next       = state;
    wait_cnt_next    = wait_cnt;
    addr_next        = P_addr;
    wdata_next       = P_wdata;
    write_next       = P_write;
    selx_next        = P_selx;
    enable_next      = P_enable;
    rsp_valid_next   = 1'b0;
    rsp_rdata_next   = rsp_rdata;
    rsp_err_next     = rsp_err;
    rsp_timeout_next = rsp_timeout;

    case (state)
      IDLE: begin
        selx_next   = 1'b0;
        enable_next = 1'b0;
        if (cmd_valid) begin
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          write_next = cmd_write;
          selx_next  = 1'b1;
          state_next = SETUP;
        end
      end

      SETUP: begin
        selx_next     = 1'b1;
        enable_next   = 1'b1;
        wait_cnt_next = '0;
        state_next    = ACCESS;
      end

      ACCESS: begin
        if (P_ready) begin
          state_next       = IDLE;
          selx_next        = 1'b0;
          enable_next      = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_err_next     = P_slverr;
          rsp_timeout_next = 1'b0;
          rsp_rdata_next   = P_write ? '0 : P_rdata;
        end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
          state_next       = IDLE;
          selx_next        = 1'b0;
          enable_next      = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          rsp_rdata_next   = '0;
        end else if (wait_cnt != '1) begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end

      default: begin
        state_next  = IDLE;
        selx_next   = 1'b0;
        enable_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master (TIMEOUT=4): table of commands with expected
// responses, a scoreboard queue filled on accept and drained on rsp_valid,
// a behavioural APB slave, and hand sequences for back-to-back and reset.
module tb_apb_master;

  logic        P_clk, P_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] P_addr;
  logic        P_selx, P_enable, P_write;
  logic [31:0] P_wdata;
  logic        P_ready, P_slverr;
  logic [31:0] P_rdata;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .P_clk(P_clk), .P_rst(P_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .P_addr(P_addr), .P_selx(P_selx), .P_enable(P_enable), .P_write(P_write),
    .P_wdata(P_wdata), .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned waits;      // ACCESS cycles the slave holds P_ready low
    logic        slverr;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int unsigned exp_acc;    // ACCESS cycles expected on the bus
    int unsigned exp_lat;    // cycle after the accept edge carrying rsp_valid
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int unsigned acc;
    int unsigned lat;
    int unsigned acc_cyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vt[8];
  int unsigned n_vec = 0, n_bad = 0, cyc = 0;

  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic        cur_write = 1'b0;
  int unsigned slv_waits = 0, acc_total = 0, cur_acc = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  logic        inflight = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0, last_to = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] wd,
                              int unsigned wt, logic se, logic [31:0] rd,
                              logic [31:0] erd, logic ee, logic eto,
                              int unsigned eacc, int unsigned elat);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.waits = wt; v.slverr = se;
    v.rdata = rd; v.exp_rdata = erd; v.exp_err = ee; v.exp_to = eto;
    v.exp_acc = eacc; v.exp_lat = elat;
    return v;
  endfunction

  initial begin
    P_clk = 1'b0;
    forever #5 P_clk = ~P_clk;
  end

  initial forever begin
    @(posedge P_clk);
    cyc++;
  end

  // Behavioural slave: drives P_ready/P_rdata/P_slverr at the negedge and
  // checks the bus is held stable through ACCESS.
  initial begin
    P_ready = 1'b0; P_slverr = 1'b0; P_rdata = '0;
    forever begin
      @(negedge P_clk);
      if (P_selx && P_enable && !P_rst) begin
        check("access_addr", P_addr, cur_addr);
        check("access_write", {31'd0, P_write}, {31'd0, cur_write});
        if (cur_write) check("access_wdata", P_wdata, cur_wdata);
        P_ready = (acc_total == slv_waits);
        acc_total++;
      end else begin
        P_ready = 1'b0;
      end
      P_rdata  = slv_rdata;
      P_slverr = slv_err;
    end
  end

  // Response monitor and bus-protocol checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge P_clk);
      if (P_rst) begin
        last_rdata = '0; last_err = 1'b0; last_to = 1'b0;
      end else begin
        check("enable_without_selx", {31'd0, P_enable & ~P_selx}, 32'd0);
        if (inflight && cyc == cur_acc) begin
          check("setup_selx", {31'd0, P_selx}, 32'd1);
          check("setup_enable", {31'd0, P_enable}, 32'd0);
          check("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        if (inflight && cyc == cur_acc + 1) begin
          check("access_selx", {31'd0, P_selx}, 32'd1);
          check("access_enable", {31'd0, P_enable}, 32'd1);
        end
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
            check("access_cycles", acc_total, e.acc);
            check("rsp_latency", cyc - e.acc_cyc + 1, e.lat);
            check("rsp_selx_low", {31'd0, P_selx}, 32'd0);
            check("rsp_enable_low", {31'd0, P_enable}, 32'd0);
            check("rsp_cmd_ready", {31'd0, cmd_ready}, 32'd1);
          end
          inflight   = 1'b0;
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
          last_to    = rsp_timeout;
        end else begin
          check("hold_rdata", rsp_rdata, last_rdata);
          check("hold_err", {31'd0, rsp_err}, {31'd0, last_err});
          check("hold_timeout", {31'd0, rsp_timeout}, {31'd0, last_to});
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    exp_t e;
    int unsigned n;
    n = 0;
    @(negedge P_clk);
    while (!cmd_ready && n < 50) begin
      @(negedge P_clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    @(posedge P_clk);
    #1;
    cmd_valid = 1'b0;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to;
    e.acc = v.exp_acc; e.lat = v.exp_lat; e.acc_cyc = cyc;
    sb.push_back(e);
    cur_addr = v.addr; cur_write = v.write; cur_wdata = v.wdata;
    slv_waits = v.waits; slv_rdata = v.rdata; slv_err = v.slverr;
    acc_total = 0;
    cur_acc   = cyc;
    inflight  = 1'b1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge P_clk);
    check("response_arrived", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    int unsigned a;
    //            wr addr      wdata         wt se rdata         exp_rdata     err to acc lat
    vt[0] = mk(1, 32'h04, 32'hDEADBEEF,  0, 0, 32'h12345678, 32'h00000000, 0, 0, 1, 3);
    vt[1] = mk(0, 32'h04, 32'h00000000,  3, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 4, 6);
    vt[2] = mk(1, 32'h08, 32'hA5A5A5A5,  0, 1, 32'h11111111, 32'h00000000, 1, 0, 1, 3);
    vt[3] = mk(0, 32'h0C, 32'h00000000,  0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 1, 3);
    vt[4] = mk(0, 32'h10, 32'h00000000, 10, 0, 32'h55AA55AA, 32'h00000000, 1, 1, 4, 6);
    vt[5] = mk(1, 32'h14, 32'h01234567,  2, 1, 32'h22222222, 32'h00000000, 1, 0, 3, 5);
    vt[6] = mk(0, 32'h18, 32'h00000000,  1, 1, 32'h0BADF00D, 32'h0BADF00D, 1, 0, 2, 4);
    vt[7] = mk(1, 32'h1C, 32'h89ABCDEF, 10, 1, 32'h33333333, 32'h00000000, 1, 1, 4, 6);

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    P_rst = 1'b0;
    #1 P_rst = 1'b1;
    #2;
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_selx", {31'd0, P_selx}, 32'd0);
    check("reset_enable", {31'd0, P_enable}, 32'd0);
    check("reset_addr", P_addr, 32'd0);
    check("reset_wdata", P_wdata, 32'd0);
    check("reset_write", {31'd0, P_write}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    repeat (2) @(posedge P_clk);
    @(negedge P_clk);
    P_rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      issue(vt[i]);
      wait_idle();
    end

    // Back-to-back zero-wait commands: accepts exactly 3 cycles apart.
    issue(vt[0]);
    a = cur_acc;
    issue(vt[3]);
    check("b2b_spacing", cur_acc - a, 32'd3);
    wait_idle();

    // Reset while in ACCESS: bus drops asynchronously, no response.
    issue(mk(0, 32'h40, 32'h0, 20, 0, 32'h77777777, 32'h0, 0, 0, 0, 0));
    for (int n = 0; n < 10 && !P_enable; n++) @(negedge P_clk);
    check("mid_reached_access", {31'd0, P_enable}, 32'd1);
    #2 P_rst = 1'b1;
    #1;
    check("mid_reset_selx", {31'd0, P_selx}, 32'd0);
    check("mid_reset_enable", {31'd0, P_enable}, 32'd0);
    check("mid_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    sb.delete();
    inflight = 1'b0;
    repeat (2) @(posedge P_clk);
    @(negedge P_clk);
    P_rst = 1'b0;
    #1;
    check("mid_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (6) @(negedge P_clk);
    issue(vt[3]);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
